// File: rtl/ah_div_pkg.sv
// Shared types for the AH pipelined divider: per-stage sideband flags and
// the accept-to-result latency helper.
package ah_div_pkg;

   typedef struct packed {
      logic valid;
      logic is_signed;
      logic neg_q;
      logic neg_r;
      logic dbz;
   } ah_div_side_t;

   function automatic int unsigned ah_div_latency(input int unsigned width);
      return width + 32'd2;
   endfunction

endpackage

// File: rtl/ah_div_step.sv
// One registered restoring-division iteration: shifts the next dividend bit
// into the partial remainder and produces one quotient bit, MSB first.
module ah_div_step
   import ah_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  ah_div_side_t     in_side,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [WIDTH-1:0] in_rem,
   input  logic [WIDTH-1:0] in_dq,
   input  logic [WIDTH-1:0] in_div,
   output ah_div_side_t     out_side,
   output logic [TAG_W-1:0] out_tag,
   output logic [WIDTH-1:0] out_rem,
   output logic [WIDTH-1:0] out_dq,
   output logic [WIDTH-1:0] out_div
);
   logic [WIDTH:0]   trial_s;
   logic [WIDTH-1:0] diff_s;
   logic             q_bit_s;

   ah_div_side_t     side_r;
   logic [TAG_W-1:0] tag_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] dq_r;
   logic [WIDTH-1:0] div_r;

   // Trial subtraction on the WIDTH+1 bit partial remainder
   always_comb begin
      trial_s = {in_rem, in_dq[WIDTH-1]};
      q_bit_s = (trial_s >= {1'b0, in_div});
      diff_s  = trial_s[WIDTH-1:0] - in_div;
   end

   // Stage register; frozen whenever the pipe is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         side_r <= '0;
         tag_r  <= '0;
         rem_r  <= '0;
         dq_r   <= '0;
         div_r  <= '0;
      end else if (en) begin
         side_r <= in_side;
         tag_r  <= in_tag;
         rem_r  <= q_bit_s ? diff_s : trial_s[WIDTH-1:0];
         dq_r   <= {in_dq[WIDTH-2:0], q_bit_s};
         div_r  <= in_div;
      end
   end

   assign out_side = side_r;
   assign out_tag  = tag_r;
   assign out_rem  = rem_r;
   assign out_dq   = dq_r;
   assign out_div  = div_r;

endmodule

// File: rtl/ah_div_pipelined_param.sv
// Parametrised pipelined divider: operand-magnitude stage, WIDTH restoring
// steps and a sign-fix output stage; the whole pipe advances as one.
module ah_div_pipelined_param
   import ah_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [TAG_W-1:0] out_tag
);
   ah_div_side_t     side_s [0:WIDTH];
   logic [TAG_W-1:0] tag_s  [0:WIDTH];
   logic [WIDTH-1:0] rem_s  [0:WIDTH];
   logic [WIDTH-1:0] dq_s   [0:WIDTH];
   logic [WIDTH-1:0] div_s  [0:WIDTH];

   logic             adv_s;
   logic             dvd_neg_s;
   logic             dvs_neg_s;
   logic             dvs_zero_s;
   ah_div_side_t     s0_side_s;
   logic [WIDTH-1:0] s0_dq_s;
   logic [WIDTH-1:0] s0_div_s;

   ah_div_side_t     s0_side_r;
   logic [TAG_W-1:0] s0_tag_r;
   logic [WIDTH-1:0] s0_dq_r;
   logic [WIDTH-1:0] s0_div_r;

   ah_div_side_t     fin_side_s;
   logic             fin_dbz_s;
   logic [WIDTH-1:0] fin_q_s;
   logic [WIDTH-1:0] fin_r_s;

   logic             out_valid_r;
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic             dbz_r;
   logic [TAG_W-1:0] out_tag_r;

   assign adv_s    = out_ready | ~out_valid_r;
   assign in_ready = adv_s;

   // Stage 0 operand conditioning: magnitudes and sign flags
   always_comb begin
      dvd_neg_s  = is_signed & dividend[WIDTH-1];
      dvs_neg_s  = is_signed & divisor[WIDTH-1];
      dvs_zero_s = (divisor == '0);
      s0_side_s           = '0;
      s0_side_s.valid     = in_valid;
      s0_side_s.is_signed = is_signed;
      s0_side_s.dbz       = dvs_zero_s;
      if (dvs_neg_s) begin
         s0_div_s = -divisor;
      end else begin
         s0_div_s = divisor;
      end
      // A zero divisor keeps the raw dividend; the steps then return it as the remainder
      if (dvs_zero_s) begin
         s0_dq_s = dividend;
      end else begin
         s0_dq_s         = dvd_neg_s ? -dividend : dividend;
         s0_side_s.neg_q = dvd_neg_s ^ dvs_neg_s;
         s0_side_s.neg_r = dvd_neg_s;
      end
   end

   // Stage 0 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_side_r <= '0;
         s0_tag_r  <= '0;
         s0_dq_r   <= '0;
         s0_div_r  <= '0;
      end else if (adv_s) begin
         s0_side_r <= s0_side_s;
         s0_tag_r  <= in_tag;
         s0_dq_r   <= s0_dq_s;
         s0_div_r  <= s0_div_s;
      end
   end

   assign side_s[0] = s0_side_r;
   assign tag_s[0]  = s0_tag_r;
   assign rem_s[0]  = '0;
   assign dq_s[0]   = s0_dq_r;
   assign div_s[0]  = s0_div_r;

   for (genvar i = 0; i < WIDTH; i++) begin : g_step
      ah_div_step #(
         .WIDTH (WIDTH),
         .TAG_W (TAG_W)
      ) u_step (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (adv_s),
         .in_side  (side_s[i]),
         .in_tag   (tag_s[i]),
         .in_rem   (rem_s[i]),
         .in_dq    (dq_s[i]),
         .in_div   (div_s[i]),
         .out_side (side_s[i+1]),
         .out_tag  (tag_s[i+1]),
         .out_rem  (rem_s[i+1]),
         .out_dq   (dq_s[i+1]),
         .out_div  (div_s[i+1])
      );
   end

   // Output sign fix; divide-by-zero results bypass it
   always_comb begin
      fin_side_s = side_s[WIDTH];
      fin_dbz_s  = fin_side_s.dbz & (div_s[WIDTH] == '0);
      if (fin_dbz_s) begin
         fin_q_s = '1;
      end else if (fin_side_s.is_signed & fin_side_s.neg_q) begin
         fin_q_s = -dq_s[WIDTH];
      end else begin
         fin_q_s = dq_s[WIDTH];
      end
      if (fin_side_s.is_signed & fin_side_s.neg_r) begin
         fin_r_s = -rem_s[WIDTH];
      end else begin
         fin_r_s = rem_s[WIDTH];
      end
   end

   // Output register; data is zeroed whenever no result is presented
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
         dbz_r       <= 1'b0;
         out_tag_r   <= '0;
      end else if (adv_s) begin
         out_valid_r <= fin_side_s.valid;
         if (fin_side_s.valid) begin
            quotient_r  <= fin_q_s;
            remainder_r <= fin_r_s;
            dbz_r       <= fin_dbz_s;
            out_tag_r   <= tag_s[WIDTH];
         end else begin
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
            out_tag_r   <= '0;
         end
      end
   end

   assign out_valid   = out_valid_r;
   assign quotient    = quotient_r;
   assign remainder   = remainder_r;
   assign div_by_zero = dbz_r;
   assign out_tag     = out_tag_r;

endmodule

// File: tb/tb_ah_div_pipelined_param.sv
// Self-checking bench for ah_div_pipelined_param (WIDTH=8, TAG_W=4) against a
// plain-arithmetic reference of truncating division with its zero/overflow rules.
module tb_ah_div_pipelined_param;
   import ah_div_pkg::*;

   localparam int W   = 8;
   localparam int TW  = 4;
   localparam int LAT = int'(ah_div_latency(W));

   typedef struct packed {
      logic [W-1:0]  q;
      logic [W-1:0]  r;
      logic          z;
      logic [TW-1:0] t;
   } exp_t;

   localparam logic [W-1:0] SG_A [3] = '{8'hF9, 8'h07, 8'h80};
   localparam logic [W-1:0] SG_B [3] = '{8'h02, 8'hFE, 8'hFF};
   localparam logic [W-1:0] SG_Q [3] = '{8'hFD, 8'hFD, 8'h80};
   localparam logic [W-1:0] SG_R [3] = '{8'hFF, 8'h01, 8'h00};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          is_signed;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;
   logic [TW-1:0] out_tag;

   int n_vec = 0;
   int n_err = 0;

   ah_div_pipelined_param #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .is_signed   (is_signed),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .out_tag     (out_tag)
   );

   always #5 clk = ~clk;

   function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s, input logic [TW-1:0] t);
      exp_t e;
      int   sa;
      int   sb;
      e.t = t;
      if (b == 8'd0) begin
         e.q = 8'hFF; e.r = a; e.z = 1'b1;
      end else if (s) begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         e.q = 8'(sa / sb); e.r = 8'(sa % sb); e.z = 1'b0;
      end else begin
         e.q = a / b; e.r = a % b; e.z = 1'b0;
      end
      return e;
   endfunction

   // Issue one op into an idle pipe and wait (bounded) for its result.
   task automatic do_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input logic [TW-1:0] t, output exp_t got, output int lat);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      dividend  = a; divisor = b; is_signed = s; in_tag = t;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 4 * LAT) begin
         @(posedge clk); #1;
         lat++;
      end
      got = '{q: quotient, r: remainder, z: div_by_zero, t: out_tag};
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0; is_signed = 1'b0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_vec++; if (quotient !== 8'h00 || remainder !== 8'h00) begin n_err++; $display("FAIL reset_data got q=%h r=%h want 00 00", quotient, remainder); end
      n_vec++; if (div_by_zero !== 1'b0 || out_tag !== 4'h0) begin n_err++; $display("FAIL reset_flags got dbz=%b tag=%h want 0 0", div_by_zero, out_tag); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL release_idle got v=%b rdy=%b want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_unsigned_latency();
      exp_t got; int lat;
      do_single(8'd100, 8'd7, 1'b0, 4'd3, got, lat);
      n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL latency got %0d want %0d", lat, LAT); end
      n_vec++; if (got.q !== 8'd14 || got.r !== 8'd2) begin n_err++; $display("FAIL u100_7 got q=%0d r=%0d want 14 2", got.q, got.r); end
      n_vec++; if (got.z !== 1'b0 || got.t !== 4'd3) begin n_err++; $display("FAIL u100_7_side got dbz=%b tag=%0d want 0 3", got.z, got.t); end
   endtask

   task automatic test_signed();
      exp_t got; int lat;
      for (int i = 0; i < 3; i++) begin
         do_single(SG_A[i], SG_B[i], 1'b1, 4'(i + 5), got, lat);
         n_vec++;
         if (got.q !== SG_Q[i] || got.r !== SG_R[i] || got.z !== 1'b0 || got.t !== 4'(i + 5)) begin
            n_err++;
            $display("FAIL signed_%0d got q=%h r=%h dbz=%b tag=%h want q=%h r=%h dbz=0 tag=%h",
                     i, got.q, got.r, got.z, got.t, SG_Q[i], SG_R[i], 4'(i + 5));
         end
      end
   endtask

   task automatic test_div_zero();
      exp_t got; int lat;
      for (int m = 0; m < 2; m++) begin
         do_single(8'd5, 8'd0, m[0], 4'hA, got, lat);
         n_vec++;
         if (got.q !== 8'hFF || got.r !== 8'h05 || got.z !== 1'b1) begin
            n_err++; $display("FAIL dbz_mode%0d got q=%h r=%h dbz=%b want ff 05 1", m, got.q, got.r, got.z);
         end
      end
      do_single(8'h80, 8'd0, 1'b1, 4'hB, got, lat);
      n_vec++;
      if (got.q !== 8'hFF || got.r !== 8'h80 || got.z !== 1'b1) begin
         n_err++; $display("FAIL dbz_min got q=%h r=%h dbz=%b want ff 80 1", got.q, got.r, got.z);
      end
      do_single(8'd9, 8'd3, 1'b0, 4'hC, got, lat);
      n_vec++;
      if (got.q !== 8'd3 || got.r !== 8'd0 || got.z !== 1'b0) begin
         n_err++; $display("FAIL after_dbz got q=%h r=%h dbz=%b want 03 00 0", got.q, got.r, got.z);
      end
   endtask

   task automatic test_back_to_back();
      exp_t exp_q[$];
      exp_t e;
      exp_t held;
      int   c = 0;
      int   issued = 0;
      int   got_n = 0;
      logic fire_in;
      in_valid = 1'b0;
      while ((issued < 20 || got_n < 20) && c < 200) begin
         out_ready = !(c >= 12 && c < 15);
         if (!in_valid && issued < 20) begin
            in_valid = 1'b1;
            dividend = W'($urandom); divisor = W'($urandom);
            is_signed = 1'($urandom_range(0, 1)); in_tag = TW'(issued);
         end
         #1;
         if (c >= 12 && c < 15) begin
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
               n_err++; $display("FAIL stall_c%0d got rdy=%b v=%b want 0 1", c, in_ready, out_valid);
            end
            if (c == 12) begin
               held = '{q: quotient, r: remainder, z: div_by_zero, t: out_tag};
            end else begin
               n_vec++;
               if ({quotient, remainder, div_by_zero, out_tag} !== held) begin
                  n_err++; $display("FAIL stall_hold_c%0d got %h want %h", c, {quotient, remainder, div_by_zero, out_tag}, held);
               end
            end
         end
         if (out_valid && out_ready) begin
            n_vec++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if ({quotient, remainder, div_by_zero, out_tag} !== e) begin
               n_err++; $display("FAIL b2b_result_%0d got q=%h r=%h z=%b t=%h want q=%h r=%h z=%b t=%h",
                                 got_n, quotient, remainder, div_by_zero, out_tag, e.q, e.r, e.z, e.t);
            end
            got_n++;
         end
         fire_in = in_valid & in_ready;
         if (fire_in) begin
            exp_q.push_back(ref_div(dividend, divisor, is_signed, in_tag));
            issued++;
         end
         @(posedge clk); #1;
         if (fire_in) in_valid = 1'b0;
         c++;
      end
      in_valid = 1'b0;
      n_vec++;
      if (got_n !== 20 || exp_q.size() !== 0) begin
         n_err++; $display("FAIL b2b_count got %0d results want 20", got_n);
      end
   endtask

   task automatic test_reset_mid();
      exp_t got; int lat; int stale = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; dividend = W'($urandom); divisor = W'($urandom_range(1, 255));
         is_signed = 1'b0; in_tag = TW'(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3 * LAT; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) stale++;
      end
      n_vec++; if (stale !== 0) begin n_err++; $display("FAIL stale_result got %0d valid cycles want 0", stale); end
      do_single(8'd9, 8'd3, 1'b0, 4'h7, got, lat);
      n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL post_reset_latency got %0d want %0d", lat, LAT); end
      n_vec++; if (got.q !== 8'd3 || got.r !== 8'd0 || got.t !== 4'h7) begin n_err++; $display("FAIL post_reset_op got q=%h r=%h t=%h want 03 00 7", got.q, got.r, got.t); end
   endtask

   task automatic test_sweep(input int n_ops);
      exp_t exp_q[$];
      exp_t e;
      int   c = 0;
      int   issued = 0;
      int   got_n = 0;
      logic fire_in;
      in_valid = 1'b0;
      while ((issued < n_ops || got_n < n_ops) && c < n_ops * 8) begin
         if (!in_valid && issued < n_ops && $urandom_range(0, 9) < 8) begin
            in_valid = 1'b1;
            dividend = ($urandom_range(0, 9) == 0) ? 8'h80 : W'($urandom);
            case ($urandom_range(0, 19))
               0, 1:    divisor = 8'h00;
               2:       divisor = 8'hFF;
               default: divisor = W'($urandom);
            endcase
            is_signed = 1'($urandom_range(0, 1));
            in_tag = TW'(issued);
         end
         out_ready = ($urandom_range(0, 9) < 8);
         #1;
         if (out_valid) begin
            if (out_ready) begin
               n_vec++;
               e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
               if ({quotient, remainder, div_by_zero, out_tag} !== e) begin
                  n_err++; $display("FAIL sweep_%0d got q=%h r=%h z=%b t=%h want q=%h r=%h z=%b t=%h",
                                    got_n, quotient, remainder, div_by_zero, out_tag, e.q, e.r, e.z, e.t);
               end
               got_n++;
            end
         end else begin
            n_vec++;
            if ({quotient, remainder, div_by_zero, out_tag} !== '0) begin
               n_err++; $display("FAIL idle_zero got q=%h r=%h z=%b t=%h want 0", quotient, remainder, div_by_zero, out_tag);
            end
         end
         fire_in = in_valid & in_ready;
         if (fire_in) begin
            exp_q.push_back(ref_div(dividend, divisor, is_signed, in_tag));
            issued++;
         end
         @(posedge clk); #1;
         if (fire_in) in_valid = 1'b0;
         c++;
      end
      in_valid = 1'b0;
      n_vec++;
      if (got_n !== n_ops) begin
         n_err++; $display("FAIL sweep_count got %0d results want %0d", got_n, n_ops);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_latency();
      test_signed();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      test_sweep(10000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
